// File: rtl/regfile_port_ctrl.sv
// Regfile port sequencer: zero-fills x1..x(NUM_REGS-1) after reset, then shares the
// write port and the rs2 read port between core writeback and a debug/loader master.
`timescale 1ns/1ps

module regfile_port_ctrl #(
  parameter int NUM_REGS   = 32,
  parameter int ADDR_W     = 5,
  parameter int DATA_W     = 32,
  parameter int MAX_WAIT   = 4,
  parameter int INIT_CLEAR = 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_core_wren,
  input  logic [ADDR_W-1:0] i_core_rd_addr,
  input  logic [DATA_W-1:0] i_core_rd_data,
  input  logic [ADDR_W-1:0] i_core_rs2_addr,
  input  logic              i_dbg_valid,
  input  logic              i_dbg_we,
  input  logic [ADDR_W-1:0] i_dbg_addr,
  input  logic [DATA_W-1:0] i_dbg_wdata,
  output logic              o_dbg_ready,
  output logic              o_dbg_rsp_valid,
  output logic [DATA_W-1:0] o_dbg_rsp_rdata,
  output logic              o_core_stall,
  output logic              o_init_done,
  output logic              o_rf_rd_wren,
  output logic [ADDR_W-1:0] o_rf_rd_addr,
  output logic [DATA_W-1:0] o_rf_rd_data,
  output logic [ADDR_W-1:0] o_rf_rs2_addr,
  input  logic [DATA_W-1:0] i_rf_rs2_data
);

  localparam int WAIT_W = $clog2(MAX_WAIT + 1);

  typedef enum logic [1:0] {
    RST_HOLD,
    INIT,
    RUN
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] clr_idx;
  logic [WAIT_W-1:0] wait_cnt;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              init_done;

  logic in_run;
  logic slot_free;
  logic wait_expired;
  logic grant_rd;
  logic grant_wr;
  logic grant_forced;

  // A debug write borrows the write port when the core is not using it, or
  // takes it by force (stalling the core) once it has waited MAX_WAIT cycles.
  assign in_run       = (state == RUN);
  assign slot_free    = ~i_core_wren | (i_core_rd_addr == '0);
  assign wait_expired = (wait_cnt == WAIT_W'(MAX_WAIT));
  assign grant_rd     = in_run & i_dbg_valid & ~i_dbg_we;
  assign grant_wr     = in_run & i_dbg_valid & i_dbg_we & (slot_free | wait_expired);
  assign grant_forced = grant_wr & ~slot_free;

  assign o_dbg_rsp_valid = rsp_valid;
  assign o_dbg_rsp_rdata = rsp_rdata;
  assign o_init_done     = init_done;

  always_comb begin
    // NOTE: every output gets a default before the case so no latch is inferred.
    o_dbg_ready   = 1'b0;
    o_core_stall  = 1'b1;
    o_rf_rd_wren  = 1'b0;
    o_rf_rd_addr  = '0;
    o_rf_rd_data  = '0;
    o_rf_rs2_addr = '0;
    case (state)
      INIT: begin
        o_rf_rd_wren = 1'b1;
        o_rf_rd_addr = clr_idx;
      end
      RUN: begin
        o_dbg_ready   = grant_rd | grant_wr;
        o_core_stall  = grant_rd | grant_forced;
        o_rf_rs2_addr = grant_rd ? i_dbg_addr : i_core_rs2_addr;
        if (grant_wr) begin
          o_rf_rd_wren = (i_dbg_addr != '0);
          o_rf_rd_addr = i_dbg_addr;
          o_rf_rd_data = i_dbg_wdata;
        end else if (!grant_rd) begin
          // While a read slot is stolen the core is frozen and its write is ignored.
          o_rf_rd_wren = i_core_wren;
          o_rf_rd_addr = i_core_rd_addr;
          o_rf_rd_data = i_core_rd_data;
        end
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= RST_HOLD;
      clr_idx   <= ADDR_W'(1);
      wait_cnt  <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      init_done <= 1'b0;
    end else begin
      rsp_valid <= grant_rd;
      if (grant_rd) begin
        rsp_rdata <= (i_dbg_addr == '0) ? '0 : i_rf_rs2_data;
      end
      case (state)
        RST_HOLD: begin
          if (INIT_CLEAR != 0) begin
            state <= INIT;
          end else begin
            state     <= RUN;
            init_done <= 1'b1;
          end
        end
        INIT: begin
          clr_idx <= clr_idx + ADDR_W'(1);
          if (clr_idx == ADDR_W'(NUM_REGS - 1)) begin
            state     <= RUN;
            init_done <= 1'b1;
          end
        end
        RUN: begin
          if (!i_dbg_valid || grant_rd || grant_wr) begin
            wait_cnt <= '0;
          end else if (!wait_expired) begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end
        default: state <= RST_HOLD;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_port_ctrl.sv
// Bench for regfile_port_ctrl: a behavioural regfile sits behind the DUT; debug read
// responses are checked against a queue of expected values filled when reads are issued.
`timescale 1ns/1ps

module tb_regfile_port_ctrl;

  localparam int NUM_REGS = 32;
  localparam int ADDR_W   = 5;
  localparam int DATA_W   = 32;
  localparam int MAX_WAIT = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              i_core_wren;
  logic [ADDR_W-1:0] i_core_rd_addr;
  logic [DATA_W-1:0] i_core_rd_data;
  logic [ADDR_W-1:0] i_core_rs2_addr;
  logic              i_dbg_valid;
  logic              i_dbg_we;
  logic [ADDR_W-1:0] i_dbg_addr;
  logic [DATA_W-1:0] i_dbg_wdata;
  logic              o_dbg_ready;
  logic              o_dbg_rsp_valid;
  logic [DATA_W-1:0] o_dbg_rsp_rdata;
  logic              o_core_stall;
  logic              o_init_done;
  logic              o_rf_rd_wren;
  logic [ADDR_W-1:0] o_rf_rd_addr;
  logic [DATA_W-1:0] o_rf_rd_data;
  logic [ADDR_W-1:0] o_rf_rs2_addr;
  logic [DATA_W-1:0] i_rf_rs2_data;

  int n_checks = 0;
  int n_fail   = 0;
  logic [DATA_W-1:0] exp_q[$];

  // Regfile model starts full of ones so the zero-fill is observable.
  logic [DATA_W-1:0] rf_mem [NUM_REGS] = '{default: '1};

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (o_rf_rd_wren) rf_mem[o_rf_rd_addr] <= o_rf_rd_data;
  end
  assign i_rf_rs2_data = rf_mem[o_rf_rs2_addr];

  regfile_port_ctrl #(
    .NUM_REGS  (NUM_REGS),
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .MAX_WAIT  (MAX_WAIT),
    .INIT_CLEAR(1)
  ) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_core_wren    (i_core_wren),
    .i_core_rd_addr (i_core_rd_addr),
    .i_core_rd_data (i_core_rd_data),
    .i_core_rs2_addr(i_core_rs2_addr),
    .i_dbg_valid    (i_dbg_valid),
    .i_dbg_we       (i_dbg_we),
    .i_dbg_addr     (i_dbg_addr),
    .i_dbg_wdata    (i_dbg_wdata),
    .o_dbg_ready    (o_dbg_ready),
    .o_dbg_rsp_valid(o_dbg_rsp_valid),
    .o_dbg_rsp_rdata(o_dbg_rsp_rdata),
    .o_core_stall   (o_core_stall),
    .o_init_done    (o_init_done),
    .o_rf_rd_wren   (o_rf_rd_wren),
    .o_rf_rd_addr   (o_rf_rd_addr),
    .o_rf_rd_data   (o_rf_rd_data),
    .o_rf_rs2_addr  (o_rf_rs2_addr),
    .i_rf_rs2_data  (i_rf_rs2_data)
  );

  task automatic check(input string tag, input logic [DATA_W-1:0] act,
                       input logic [DATA_W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Response side of the scoreboard.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && o_dbg_rsp_valid === 1'b1) begin
      if (exp_q.size() == 0) check("rsp_unexpected", 32'd1, 32'd0);
      else                   check("rsp_rdata", o_dbg_rsp_rdata, exp_q.pop_front());
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    i_core_wren    = 1'b0;
    i_core_rd_addr = '0;
    i_core_rd_data = '0;
    i_dbg_valid    = 1'b0;
    i_dbg_we       = 1'b0;
    i_dbg_addr     = '0;
    i_dbg_wdata    = '0;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_ready"},     32'(o_dbg_ready),     32'd0);
    check({tag, "_rsp_valid"}, 32'(o_dbg_rsp_valid), 32'd0);
    check({tag, "_rsp_rdata"}, o_dbg_rsp_rdata,      32'd0);
    check({tag, "_stall"},     32'(o_core_stall),    32'd1);
    check({tag, "_init_done"}, 32'(o_init_done),     32'd0);
    check({tag, "_wren"},      32'(o_rf_rd_wren),    32'd0);
    check({tag, "_rd_addr"},   32'(o_rf_rd_addr),    32'd0);
    check({tag, "_rd_data"},   o_rf_rd_data,         32'd0);
    check({tag, "_rs2_addr"},  32'(o_rf_rs2_addr),   32'd0);
  endtask

  // Entered in the RST_HOLD cycle; returns in the first RUN cycle before its
  // negedge, or at the negedge where the fill address equals stop_at.
  task automatic run_init(input int stop_at);
    @(negedge clk);
    check_reset("hold");
    for (int i = 1; i < NUM_REGS; i++) begin
      step();
      @(negedge clk);
      check("init_wren",      32'(o_rf_rd_wren),  32'd1);
      check("init_addr",      32'(o_rf_rd_addr),  32'(i));
      check("init_data",      o_rf_rd_data,       32'd0);
      check("init_stall",     32'(o_core_stall),  32'd1);
      check("init_ready",     32'(o_dbg_ready),   32'd0);
      check("init_done_low",  32'(o_init_done),   32'd0);
      if (i == stop_at) return;
    end
    step();
  endtask

  task automatic core_write(input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data);
    i_core_wren = 1'b1; i_core_rd_addr = addr; i_core_rd_data = data;
    @(negedge clk);
    check("core_wr_wren",  32'(o_rf_rd_wren), 32'd1);
    check("core_wr_addr",  32'(o_rf_rd_addr), 32'(addr));
    check("core_wr_data",  o_rf_rd_data,      data);
    check("core_wr_stall", 32'(o_core_stall), 32'd0);
    step();
    i_core_wren = 1'b0;
  endtask

  task automatic dbg_read(input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] exp);
    i_dbg_valid = 1'b1; i_dbg_we = 1'b0; i_dbg_addr = addr;
    @(negedge clk);
    check("rd_ready",    32'(o_dbg_ready),   32'd1);
    check("rd_stall",    32'(o_core_stall),  32'd1);
    check("rd_rs2_addr", 32'(o_rf_rs2_addr), 32'(addr));
    exp_q.push_back(exp);
    step();
    i_dbg_valid = 1'b0;
  endtask

  // Debug write into a free slot: core idle, or core writing x0 when core_x0=1.
  task automatic dbg_write_free(input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data,
                                input logic core_x0);
    i_core_wren = core_x0; i_core_rd_addr = '0; i_core_rd_data = 32'h1111_1111;
    i_dbg_valid = 1'b1; i_dbg_we = 1'b1; i_dbg_addr = addr; i_dbg_wdata = data;
    @(negedge clk);
    check("wr_free_ready", 32'(o_dbg_ready),  32'd1);
    check("wr_free_stall", 32'(o_core_stall), 32'd0);
    check("wr_free_wren",  32'(o_rf_rd_wren), (addr != '0) ? 32'd1 : 32'd0);
    if (addr != '0) begin
      check("wr_free_addr", 32'(o_rf_rd_addr), 32'(addr));
      check("wr_free_data", o_rf_rd_data,      data);
    end
    step();
    idle_inputs();
  endtask

  // Core writes x10 every cycle; the debug write waits MAX_WAIT cycles, is forced
  // in with a stall, and the dropped core write is re-issued the following cycle.
  task automatic dbg_write_busy(input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data,
                                input logic [DATA_W-1:0] base);
    i_dbg_valid = 1'b1; i_dbg_we = 1'b1; i_dbg_addr = addr; i_dbg_wdata = data;
    for (int c = 0; c <= MAX_WAIT; c++) begin
      i_core_wren = 1'b1; i_core_rd_addr = 5'd10; i_core_rd_data = base + 32'(c);
      @(negedge clk);
      if (c < MAX_WAIT) begin
        check("wr_wait_ready", 32'(o_dbg_ready),  32'd0);
        check("wr_wait_stall", 32'(o_core_stall), 32'd0);
        check("wr_wait_addr",  32'(o_rf_rd_addr), 32'd10);
        check("wr_wait_data",  o_rf_rd_data,      base + 32'(c));
      end else begin
        check("wr_force_ready", 32'(o_dbg_ready),  32'd1);
        check("wr_force_stall", 32'(o_core_stall), 32'd1);
        check("wr_force_wren",  32'(o_rf_rd_wren), 32'd1);
        check("wr_force_addr",  32'(o_rf_rd_addr), 32'(addr));
        check("wr_force_data",  o_rf_rd_data,      data);
      end
      step();
    end
    i_dbg_valid = 1'b0;
    @(negedge clk);
    check("core_reissue_wren",  32'(o_rf_rd_wren), 32'd1);
    check("core_reissue_addr",  32'(o_rf_rd_addr), 32'd10);
    check("core_reissue_data",  o_rf_rd_data,      base + 32'(MAX_WAIT));
    check("core_reissue_stall", 32'(o_core_stall), 32'd0);
    step();
    idle_inputs();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle_inputs();
    i_core_rs2_addr = '0;
    repeat (2) @(posedge clk);
    #1;
    check_reset("reset");
    @(posedge clk);
    #1 rst_n = 1'b1;

    // A debug read held through INIT is not accepted until the first RUN cycle.
    i_dbg_valid = 1'b1; i_dbg_we = 1'b0; i_dbg_addr = 5'd1;
    run_init(0);
    @(negedge clk);
    check("run_init_done",   32'(o_init_done),  32'd1);
    check("run_first_ready", 32'(o_dbg_ready),  32'd1);
    check("run_first_stall", 32'(o_core_stall), 32'd1);
    exp_q.push_back(32'd0);
    step();
    idle_inputs();

    i_core_rs2_addr = 5'd9;
    @(negedge clk);
    check("rs2_pass_addr", 32'(o_rf_rs2_addr), 32'd9);
    check("idle_stall",    32'(o_core_stall),  32'd0);
    check("idle_ready",    32'(o_dbg_ready),   32'd0);
    step();

    core_write(5'd5, 32'h0000_1234);
    dbg_read(5'd5, 32'h0000_1234);
    step();
    @(negedge clk);
    check("rsp_pulse_low",  32'(o_dbg_rsp_valid), 32'd0);
    check("rsp_rdata_held", o_dbg_rsp_rdata,      32'h0000_1234);
    step();

    dbg_write_free(5'd7, 32'hDEAD_BEEF, 1'b0);
    dbg_read(5'd7, 32'hDEAD_BEEF);
    dbg_write_free(5'd8, 32'h55AA_55AA, 1'b1);
    dbg_read(5'd8, 32'h55AA_55AA);

    // Back-to-back reads.
    dbg_read(5'd1, 32'd0);
    dbg_read(5'd7, 32'hDEAD_BEEF);
    dbg_read(5'd5, 32'h0000_1234);
    dbg_read(5'd2, 32'd0);

    dbg_write_busy(5'd3, 32'hCAFE_BABE, 32'h100);
    dbg_read(5'd3, 32'hCAFE_BABE);
    dbg_read(5'd10, 32'h104);

    // Dropping valid mid-wait restarts the wait count.
    i_dbg_valid = 1'b1; i_dbg_we = 1'b1; i_dbg_addr = 5'd4; i_dbg_wdata = 32'h0F0F_0F0F;
    for (int c = 0; c < 2; c++) begin
      i_core_wren = 1'b1; i_core_rd_addr = 5'd10; i_core_rd_data = 32'h1F0 + 32'(c);
      @(negedge clk);
      check("wr_pre_wait_ready", 32'(o_dbg_ready), 32'd0);
      step();
    end
    i_dbg_valid = 1'b0;
    step();
    dbg_write_busy(5'd4, 32'h0F0F_0F0F, 32'h200);
    dbg_read(5'd4, 32'h0F0F_0F0F);
    dbg_read(5'd10, 32'h204);

    dbg_write_free(5'd0, 32'h0BAD_CAFE, 1'b0);
    dbg_read(5'd0, 32'd0);
    dbg_read(5'd3, 32'hCAFE_BABE);
    repeat (2) step();

    // Reset while a debug write is pending behind a busy core.
    i_dbg_valid = 1'b1; i_dbg_we = 1'b1; i_dbg_addr = 5'd3; i_dbg_wdata = 32'h1234_5678;
    i_core_wren = 1'b1; i_core_rd_addr = 5'd10; i_core_rd_data = 32'h300;
    repeat (2) step();
    rst_n = 1'b0;
    #1;
    check_reset("rst_pending");
    @(posedge clk);
    idle_inputs();
    #1 rst_n = 1'b1;

    // Reset in the middle of the zero-fill; it restarts from x1.
    run_init(10);
    #2 rst_n = 1'b0;
    #1;
    check_reset("rst_mid_init");
    @(posedge clk);
    #1 rst_n = 1'b1;
    run_init(0);

    dbg_read(5'd3, 32'd0);
    dbg_read(5'd10, 32'd0);
    dbg_read(5'd7, 32'd0);
    repeat (2) step();
    check("rsp_queue_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
